ssd1306_spi_receiver: RTL and testbench
=======================================

Name: ssd1306_spi_receiver

Overview:
- Behavioural and synthesizable model of the SSD1306 panel end of the display SPI link.
- Acts as a mode-0 SPI slave oversampled by the system clock. Uses D/C to split bytes into commands and GDDRAM data.
- Decodes addressing commands and writes data bytes into a 1024-byte framebuffer port with SSD1306 auto-increment rules.
- Used in benches (and on-FPGA loopback) to check the display driver's init, frame and streaming sequences end to end.

Parameters:
- RESET_ADDR_MODE, 2'd2, addressing mode after reset: 0 = horizontal, 1 = vertical, 2 = page.
- COL_MAX, 7'd127, reset column end address.
- PAGE_MAX, 3'd7, reset page end address.

Ports:
- i_Clk  in  1  system clock. Must be at least 4x the SCLK frequency.
- i_Reset  in  1  synchronous, active-high reset.
- i_SPI_Clk  in  1  SCLK (D0), asynchronous.
- i_SPI_MOSI  in  1  serial data (D1), asynchronous.
- i_SPI_CS_n  in  1  chip select, active low, asynchronous.
- i_DC  in  1  0 = command byte, 1 = data byte. Sampled with the 8th bit.
- o_Byte  out  8  last completed byte.
- o_Byte_Valid  out  1  one-cycle pulse per completed byte.
- o_Byte_Is_Data  out  1  D/C value captured with o_Byte.
- o_Fb_Addr  out  10  framebuffer address {page[2:0], col[6:0]}.
- o_Fb_Data  out  8  framebuffer write data.
- o_Fb_WE  out  1  one-cycle framebuffer write strobe.
- o_Display_On  out  1  set by 0xAF, cleared by 0xAE.
- o_Frame_Done  out  1  one-cycle pulse when the write pointer wraps from end to start.

Behaviour:
- Input synchronisation: SCLK, MOSI, CS_n and DC each pass through a 2-flop synchroniser.
- Bit capture:
  - A rising edge is sync SCLK high while the previous sample was low.
  - On a rising edge with CS_n low, shift MOSI in MSB first and increment a 3-bit bit counter.
  - On the 8th edge, latch the byte and DC. o_Byte_Valid pulses on the next i_Clk.
- Latency: o_Byte_Valid, and o_Fb_WE for data bytes, assert exactly 3 i_Clk cycles after the first i_Clk edge that samples raw SCLK high for bit 8.
- Chip select: sync CS_n high clears the bit counter and discards a partial byte. If CS_n high coincides with the 8th edge, no byte is produced; CS_n has priority.
- Reset values: o_Byte = 0, o_Byte_Valid = 0, o_Byte_Is_Data = 0, o_Fb_Addr = 0, o_Fb_Data = 0, o_Fb_WE = 0, o_Display_On = 0, o_Frame_Done = 0. Pointers: col = 0, page = 0, col_start = 0, col_end = COL_MAX, page_start = 0, page_end = PAGE_MAX, mode = RESET_ADDR_MODE. Parser state = P_OPCODE; bit counter = 0.
- Command parser FSM (advances on command bytes only; data bytes never change parser state):
  - P_OPCODE: 0x21 -> P_COL_S; 0x22 -> P_PAGE_S; 0x20 -> P_MODE.
  - P_OPCODE: 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB -> P_SKIP1.
  - P_OPCODE: 0xAE/0xAF set o_Display_On. Any other opcode is ignored and the state stays P_OPCODE.
  - P_COL_S: col_start = arg[6:0] -> P_COL_E.
  - P_COL_E: col_end = arg[6:0], then col = col_start -> P_OPCODE.
  - P_PAGE_S: page_start = arg[2:0] -> P_PAGE_E.
  - P_PAGE_E: page_end = arg[2:0], then page = page_start -> P_OPCODE.
  - P_MODE: mode = arg[1:0] unless arg[1:0] == 3, which is ignored -> P_OPCODE.
  - P_SKIP1: discard the byte -> P_OPCODE.
- Data byte handling:
  - o_Fb_Addr = {page, col} before increment, o_Fb_Data = byte, o_Fb_WE pulses.
  - The pointer then advances according to the addressing mode.
- Horizontal mode: if col == col_end then col = col_start and page advances, else col++. Page advance: if page == page_end then page = page_start and o_Frame_Done pulses, else page++.
- Vertical mode: page advances first. On page wrap, col advances. o_Frame_Done pulses when both wrap.
- Page mode: if col == col_end then col = col_start, else col++. page is unchanged; o_Frame_Done never pulses.
- If start > end, the increment still compares with ==, so the pointer runs to the 7-bit/3-bit maximum and wraps through 0.
- A reset asserted mid-byte or mid-command restores all reset values on that clock.

Test Plan:
- Reset, then send cmd 0xAF -> o_Byte = 0xAF, o_Byte_Is_Data = 0, o_Display_On = 1, no o_Fb_WE.
- Send cmds 0x20 0x00, 0x21 0x00 0x7F, 0x22 0x00 0x07, then 1024 data bytes (value = index[7:0]) -> 1024 writes at addresses 0..1023 with matching data, and o_Frame_Done pulses exactly once, on the 1024th.
- Page mode (reset default), cmds 0x21 0x7E 0x7F, then 3 data bytes -> addresses 126, 127, 126; page stays 0.
- Send 5 bits, raise CS_n, then a full byte 0xA5 with DC = 1 -> exactly one write, data 0xA5; the partial byte is discarded.
- Send cmd 0x81 then cmd 0x21 -> 0x21 is consumed as the contrast argument, and the parser returns to P_OPCODE.
- Vertical mode 0x20 0x01, pages 0..1, cols 0..1, 4 data bytes -> addresses 0, 128, 1, 129, with o_Frame_Done on the 4th byte.

Source files
------------

// File: rtl/ssd1306_spi_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ssd1306_spi_receiver
// Brief    : Panel-side model of the SSD1306 4-wire SPI link. Oversamples a
//            mode-0 SPI stream with the system clock, splits bytes into
//            commands and GDDRAM data using D/C, decodes the addressing
//            commands and emits framebuffer writes with SSD1306 pointer
//            auto-increment behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module ssd1306_spi_receiver #(
    parameter logic [1:0] RESET_ADDR_MODE = 2'd2,
    parameter logic [6:0] COL_MAX         = 7'd127,
    parameter logic [2:0] PAGE_MAX        = 3'd7
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n,
    input  logic       i_DC,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Valid,
    output logic       o_Byte_Is_Data,
    output logic [9:0] o_Fb_Addr,
    output logic [7:0] o_Fb_Data,
    output logic       o_Fb_WE,
    output logic       o_Display_On,
    output logic       o_Frame_Done
);

    typedef enum logic [2:0] {
        P_OPCODE = 3'd0,
        P_COL_S  = 3'd1,
        P_COL_E  = 3'd2,
        P_PAGE_S = 3'd3,
        P_PAGE_E = 3'd4,
        P_MODE   = 3'd5,
        P_SKIP1  = 3'd6
    } parser_state_t;

    // Two-flop synchronisers plus the previous SCLK sample for edge detection
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_mosi_meta, r_mosi_sync;
    logic r_cs_meta,   r_cs_sync;
    logic r_dc_meta,   r_dc_sync;

    // Byte assembly
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_rx_byte;
    logic       r_rx_dc;
    logic       r_rx_done;

    // Command parser and GDDRAM pointers
    parser_state_t r_state, w_state_next;
    logic [6:0]    r_col, r_col_start, r_col_end;
    logic [2:0]    r_page, r_page_start, r_page_end;
    logic [1:0]    r_mode;

    logic       w_sclk_rise;
    logic       w_col_at_end, w_page_at_end;
    logic [6:0] w_col_adv, w_col_next;
    logic [2:0] w_page_adv, w_page_next;
    logic       w_frame_wrap;

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;

    // Bring the asynchronous SPI pins into the i_Clk domain
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_dc_meta   <= 1'b0;
            r_dc_sync   <= 1'b0;
        end else begin
            r_sclk_meta <= i_SPI_Clk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= i_SPI_MOSI;
            r_mosi_sync <= r_mosi_meta;
            r_cs_meta   <= i_SPI_CS_n;
            r_cs_sync   <= r_cs_meta;
            r_dc_meta   <= i_DC;
            r_dc_sync   <= r_dc_meta;
        end
    end

    // Shift MOSI in MSB first; a deselected chip drops any partial byte
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
            r_rx_byte <= 8'd0;
            r_rx_dc   <= 1'b0;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (r_cs_sync) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[5:0], r_mosi_sync};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_byte <= {r_shift, r_mosi_sync};
                    r_rx_dc   <= r_dc_sync;
                    r_rx_done <= 1'b1;
                end
            end
        end
    end

    // Parser state register, advanced by command bytes only
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= P_OPCODE;
        end else if (r_rx_done && !r_rx_dc) begin
            r_state <= w_state_next;
        end
    end

    // Parser next state: opcodes with arguments route to their argument states
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            P_OPCODE: begin
                case (r_rx_byte)
                    8'h21:   w_state_next = P_COL_S;
                    8'h22:   w_state_next = P_PAGE_S;
                    8'h20:   w_state_next = P_MODE;
                    8'h81, 8'h8D, 8'hA8, 8'hD3,
                    8'hD5, 8'hD9, 8'hDA, 8'hDB:
                             w_state_next = P_SKIP1;
                    default: w_state_next = P_OPCODE;
                endcase
            end
            P_COL_S:  w_state_next = P_COL_E;
            P_PAGE_S: w_state_next = P_PAGE_E;
            default:  w_state_next = P_OPCODE;
        endcase
    end

    // Pointer advance; equality compares let start > end windows wrap through 0
    always_comb begin
        w_col_at_end  = (r_col == r_col_end);
        w_page_at_end = (r_page == r_page_end);
        w_col_adv     = w_col_at_end  ? r_col_start  : r_col + 7'd1;
        w_page_adv    = w_page_at_end ? r_page_start : r_page + 3'd1;
        w_col_next    = r_col;
        w_page_next   = r_page;
        w_frame_wrap  = 1'b0;
        case (r_mode)
            2'd0: begin
                w_col_next = w_col_adv;
                if (w_col_at_end) begin
                    w_page_next  = w_page_adv;
                    w_frame_wrap = w_page_at_end;
                end
            end
            2'd1: begin
                w_page_next = w_page_adv;
                if (w_page_at_end) begin
                    w_col_next   = w_col_adv;
                    w_frame_wrap = w_col_at_end;
                end
            end
            default: begin
                w_col_next = w_col_adv;
            end
        endcase
    end

    // Publish completed bytes, perform framebuffer writes and apply commands
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Byte         <= 8'd0;
            o_Byte_Valid   <= 1'b0;
            o_Byte_Is_Data <= 1'b0;
            o_Fb_Addr      <= 10'd0;
            o_Fb_Data      <= 8'd0;
            o_Fb_WE        <= 1'b0;
            o_Display_On   <= 1'b0;
            o_Frame_Done   <= 1'b0;
            r_col          <= 7'd0;
            r_page         <= 3'd0;
            r_col_start    <= 7'd0;
            r_col_end      <= COL_MAX;
            r_page_start   <= 3'd0;
            r_page_end     <= PAGE_MAX;
            r_mode         <= RESET_ADDR_MODE;
        end else begin
            o_Byte_Valid <= 1'b0;
            o_Fb_WE      <= 1'b0;
            o_Frame_Done <= 1'b0;
            if (r_rx_done) begin
                o_Byte         <= r_rx_byte;
                o_Byte_Is_Data <= r_rx_dc;
                o_Byte_Valid   <= 1'b1;
                if (r_rx_dc) begin
                    o_Fb_WE      <= 1'b1;
                    o_Fb_Addr    <= {r_page, r_col};
                    o_Fb_Data    <= r_rx_byte;
                    o_Frame_Done <= w_frame_wrap;
                    r_col        <= w_col_next;
                    r_page       <= w_page_next;
                end else begin
                    case (r_state)
                        P_OPCODE: begin
                            if (r_rx_byte == 8'hAE) o_Display_On <= 1'b0;
                            if (r_rx_byte == 8'hAF) o_Display_On <= 1'b1;
                        end
                        P_COL_S:  r_col_start <= r_rx_byte[6:0];
                        P_COL_E: begin
                            r_col_end <= r_rx_byte[6:0];
                            r_col     <= r_col_start;
                        end
                        P_PAGE_S: r_page_start <= r_rx_byte[2:0];
                        P_PAGE_E: begin
                            r_page_end <= r_rx_byte[2:0];
                            r_page     <= r_page_start;
                        end
                        P_MODE: begin
                            if (r_rx_byte[1:0] != 2'b11) r_mode <= r_rx_byte[1:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd1306_spi_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ssd1306_spi_receiver
// Brief    : Scoreboard bench for ssd1306_spi_receiver. Stimulus drives SPI
//            bytes and pushes the reference model's expected byte events; a
//            monitor pops and compares on every o_Byte_Valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd1306_spi_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, mosi, cs_n, dc;
    logic [7:0] o_byte, o_fb_data;
    logic       o_byte_valid, o_byte_is_data, o_fb_we, o_display_on, o_frame_done;
    logic [9:0] o_fb_addr;

    always #5 clk = ~clk;

    ssd1306_spi_receiver #(
        .RESET_ADDR_MODE (2'd2),
        .COL_MAX         (7'd127),
        .PAGE_MAX        (3'd7)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_SPI_Clk      (sclk),
        .i_SPI_MOSI     (mosi),
        .i_SPI_CS_n     (cs_n),
        .i_DC           (dc),
        .o_Byte         (o_byte),
        .o_Byte_Valid   (o_byte_valid),
        .o_Byte_Is_Data (o_byte_is_data),
        .o_Fb_Addr      (o_fb_addr),
        .o_Fb_Data      (o_fb_data),
        .o_Fb_WE        (o_fb_we),
        .o_Display_On   (o_display_on),
        .o_Frame_Done   (o_frame_done)
    );

    typedef struct {
        logic [7:0] b;
        logic       is_data;
        logic [9:0] addr;
        logic       fdone;
        logic       disp;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (register-map level) ----------------
    // Pending argument kinds: what the next command byte will be taken as.
    localparam int ARG_NONE = 0, ARG_COL_S = 1, ARG_COL_E = 2, ARG_PAGE_S = 3,
                   ARG_PAGE_E = 4, ARG_MODE = 5, ARG_SKIP = 6;
    int m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_pend;
    bit m_disp;

    task automatic model_reset();
        m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
        m_col = 0; m_page = 0; m_pend = ARG_NONE; m_disp = 0;
    endtask

    function automatic int step(int v, int last, int first, int modn);
        return (v == last) ? first : (v + 1) % modn;
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic d);
        exp_t x;
        int   v;
        x.b = b; x.is_data = d; x.addr = '0; x.fdone = 1'b0;
        v = int'(b);
        if (d) begin
            x.addr = 10'(m_page * 128 + m_col);
            case (m_mode)
                0: begin
                    if (m_col == m_ce) begin
                        if (m_page == m_pe) x.fdone = 1'b1;
                        m_page = step(m_page, m_pe, m_ps, 8);
                    end
                    m_col = step(m_col, m_ce, m_cs, 128);
                end
                1: begin
                    if (m_page == m_pe) begin
                        if (m_col == m_ce) x.fdone = 1'b1;
                        m_col = step(m_col, m_ce, m_cs, 128);
                    end
                    m_page = step(m_page, m_pe, m_ps, 8);
                end
                default: m_col = step(m_col, m_ce, m_cs, 128);
            endcase
        end else begin
            case (m_pend)
                ARG_NONE: begin
                    if (v == 'h21)      m_pend = ARG_COL_S;
                    else if (v == 'h22) m_pend = ARG_PAGE_S;
                    else if (v == 'h20) m_pend = ARG_MODE;
                    else if (v inside {'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB})
                        m_pend = ARG_SKIP;
                    else if (v == 'hAE) m_disp = 0;
                    else if (v == 'hAF) m_disp = 1;
                end
                ARG_COL_S:  begin m_cs = v % 128; m_pend = ARG_COL_E; end
                ARG_COL_E:  begin m_ce = v % 128; m_col = m_cs; m_pend = ARG_NONE; end
                ARG_PAGE_S: begin m_ps = v % 8; m_pend = ARG_PAGE_E; end
                ARG_PAGE_E: begin m_pe = v % 8; m_page = m_ps; m_pend = ARG_NONE; end
                ARG_MODE:   begin if (v % 4 != 3) m_mode = v % 4; m_pend = ARG_NONE; end
                default:    m_pend = ARG_NONE;
            endcase
        end
        x.disp = m_disp;
        // The last SCLK high was first sampled one clock after it was driven;
        // the byte is due three clocks after that, i.e. two clocks from now.
        x.cyc = cyc + 2;
        q.push_back(x);
    endtask

    // ---------------- stimulus helpers ----------------
    // Each bit: two clocks low then two clocks high (SCLK = clk/4).
    task automatic send_bit(input logic b);
        mosi = b;
        repeat (2) @(posedge clk);
        #3 sclk = 1'b1;
        repeat (2) @(posedge clk);
        #3 sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        dc = d;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        model_byte(b, d);
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic do_reset(input logic keep_cs_low);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        sclk = 1'b0;
        if (!keep_cs_low) cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_byte",     32'(o_byte),         32'h0);
        check("rst_valid",    32'(o_byte_valid),   32'h0);
        check("rst_is_data",  32'(o_byte_is_data), 32'h0);
        check("rst_fb_addr",  32'(o_fb_addr),      32'h0);
        check("rst_fb_data",  32'(o_fb_data),      32'h0);
        check("rst_fb_we",    32'(o_fb_we),        32'h0);
        check("rst_disp_on",  32'(o_display_on),   32'h0);
        check("rst_frame",    32'(o_frame_done),   32'h0);
        model_reset();
        rst  = 1'b0;
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #3;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (o_byte_valid) begin
                if (q.size() == 0) begin
                    check("extra_byte_valid", 32'(o_byte_valid), 32'h0);
                end else begin
                    e = q.pop_front();
                    check("latency",     32'(cyc),            32'(e.cyc));
                    check("byte",        32'(o_byte),         32'(e.b));
                    check("is_data",     32'(o_byte_is_data), 32'(e.is_data));
                    check("fb_we",       32'(o_fb_we),        32'(e.is_data));
                    check("frame_done",  32'(o_frame_done),   32'(e.fdone));
                    check("display_on",  32'(o_display_on),   32'(e.disp));
                    if (e.is_data) begin
                        check("fb_addr", 32'(o_fb_addr), 32'(e.addr));
                        check("fb_data", 32'(o_fb_data), 32'(e.b));
                    end
                end
            end else if (o_fb_we || o_frame_done) begin
                check("stray_strobe", 32'({o_fb_we, o_frame_done}), 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] skip_ops [8] = '{8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};

    initial begin
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; dc = 1'b0;
        model_reset();
        do_reset(1'b0);

        // Display on
        send_byte(8'hAF, 1'b0);

        // Horizontal full-screen frame: 1024 writes, one frame-done at the end
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h07, 1'b0);
        for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b1);

        // Page mode with a two-column window
        do_reset(1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);

        // Partial byte dropped by CS_n
        dc = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        repeat (2) @(posedge clk);
        #3 cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #3 cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        send_byte(8'hA5, 1'b1);

        // 0x21 swallowed as the contrast argument; 0xAE must parse as opcode
        send_byte(8'h81, 1'b0); send_byte(8'h21, 1'b0);
        send_byte(8'hAE, 1'b0); send_byte(8'hAF, 1'b0);

        // Vertical mode, 2x2 window
        do_reset(1'b0);
        send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);

        // Reset in the middle of a byte
        dc = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        do_reset(1'b1);
        send_byte(8'hAF, 1'b0);

        // Randomised command/data mix
        for (int k = 0; k < 300; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3, 4: send_byte(8'($urandom), 1'b1);
                5: begin send_byte(8'h20, 1'b0); send_byte(8'($urandom), 1'b0); end
                6: begin
                    send_byte(8'h21, 1'b0);
                    send_byte(8'($urandom), 1'b0); send_byte(8'($urandom), 1'b0);
                end
                7: begin
                    send_byte(8'h22, 1'b0);
                    send_byte(8'($urandom), 1'b0); send_byte(8'($urandom), 1'b0);
                end
                8: begin
                    send_byte(skip_ops[$urandom_range(0, 7)], 1'b0);
                    send_byte(8'($urandom), 1'b0);
                end
                default: send_byte(8'($urandom), 1'b0);
            endcase
        end

        repeat (10) @(posedge clk);
        #3;
        check("pending_expected", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
